// File: rtl/cordic_gain_comp.sv
// Purpose : removes the CORDIC vectoring gain from a raw magnitude by multiplying
//           it with K = 1/An (Q1.15), using a 16-step shift-add multiplier.
// Latency : 16 cycles from the acceptance edge to out_valid; 18 cycles per result minimum.
// Backpressure: one operand in flight; in_ready is low from acceptance until the
//           result has been taken. The result is held in DONE for as long as out_ready is low.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/x_in       operand handshake, signed WIDTH-bit raw magnitude
//   out_valid/out_ready/mag_out  result handshake, signed WIDTH-bit compensated magnitude
module cordic_gain_comp #(
    parameter int WIDTH = 32,
    parameter int K_Q15 = 19898,
    parameter int FRAC  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag_out
);

    // 16 guard bits: |x * K| < |x| * 2^16, so the accumulator can never overflow.
    localparam int AW = WIDTH + 16;
    localparam logic [15:0] K_BITS = 16'(K_Q15);
    // Half an output LSB, added before the final shift for round-half-up.
    localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [AW-1:0]    x_q;
    logic signed [AW-1:0]    acc_q;
    logic [3:0]              cnt_q;
    logic signed [WIDTH-1:0] mag_q;

    logic signed [AW-1:0]    addend;
    logic signed [AW-1:0]    acc_sum;
    logic signed [AW-1:0]    rnd_sum;
    logic signed [WIDTH-1:0] mag_d;
    logic                    accept;
    logic                    unused_bits;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = CALC;
            CALC:    if (cnt_q == 4'd15)  state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // in_ready is gated by rst_n so it reads 0 while reset is held even though
    // the state register already sits in IDLE.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign accept  = in_valid && in_ready;
    assign mag_out = mag_q;

    // ---------------- shift-add datapath ----------------
    always_comb begin
        addend  = K_BITS[cnt_q] ? (x_q <<< cnt_q) : '0;
        acc_sum = acc_q + addend;
        rnd_sum = acc_sum + RND;
        // Taking bits [FRAC +: WIDTH] of the rounded sum is the arithmetic shift
        // right by FRAC followed by truncation to WIDTH.
        mag_d   = rnd_sum[FRAC +: WIDTH];
    end

    // Bits below the output LSB and the top guard bit are only needed for carries.
    assign unused_bits = ^{rnd_sum[FRAC-1:0], rnd_sum[AW-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            mag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q   <= {{(AW-WIDTH){x_in[WIDTH-1]}}, x_in};
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 4'd1;
                    // The last step registers the result using the sum that
                    // already includes the bit-15 term.
                    if (cnt_q == 4'd15) begin
                        mag_q <= mag_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_gain_comp.sv
module tb_cordic_gain_comp;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] mag_out;

    int tests;
    int fails;

    cordic_gain_comp #(.WIDTH(32), .K_Q15(19898), .FRAC(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] exp;
    } vec_t;

    // Reference: round(x * 19898 / 2^15) with ties toward +inf, in plain integer arithmetic.
    function automatic logic signed [31:0] ref_mag(input logic signed [31:0] x);
        longint p;
        p = (longint'(x) * 64'sd19898 + 64'sd16384) >>> 15;
        return p[31:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents x for exactly one acceptance edge.
    // Returns at acceptance edge + 1 time unit.
    task automatic accept_op(input logic signed [31:0] x, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ready_wait"}, longint'(n < 50), 1);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in     = $urandom;
    endtask

    // Counts edges until out_valid after an acceptance; checks latency, value and
    // that in_ready stays low throughout the calculation.
    task automatic wait_result(input logic signed [31:0] exp, input string name);
        int  lat;
        logic rdy_seen;
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 16);
        chk({name, "_mag"}, mag_out, exp);
        chk({name, "_in_ready_calc"}, rdy_seen, 0);
    endtask

    // Full transaction with out_ready already high: DONE lasts exactly one cycle.
    task automatic do_op(input logic signed [31:0] x, input logic signed [31:0] exp, input string name);
        accept_op(x, name);
        wait_result(exp, name);
        @(posedge clk); #1;
        chk({name, "_valid_clear"}, out_valid, 0);
        chk({name, "_mag_hold"}, mag_out, exp);
    endtask

    vec_t vecs[8];

    initial begin
        logic signed [31:0] held;
        logic signed [31:0] xr;
        logic               stable;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;

        vecs[0] = '{32'sd32768,       32'sd19898};
        vecs[1] = '{32'sd100000,      32'sd60724};
        vecs[2] = '{-32'sd100000,     -32'sd60724};
        vecs[3] = '{32'sd2147483647,  32'sd1304035327};
        vecs[4] = '{32'sd0,           32'sd0};
        vecs[5] = '{-32'sd2147483648, -32'sd1304035328};
        vecs[6] = '{32'sd1,           32'sd1};
        vecs[7] = '{-32'sd1,          -32'sd1};

        // ---- reset: inputs toggling while held in reset ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            x_in      = $urandom;
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_mag_out", mag_out, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        // ---- directed vector table ----
        foreach (vecs[i]) begin
            do_op(vecs[i].x, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // ---- randomized operands against the reference model ----
        for (int i = 0; i < 20; i++) begin
            xr = $urandom;
            if (i % 4 == 0) xr = 32'(signed'(xr) >>> 12);
            do_op(xr, ref_mag(xr), $sformatf("rnd%0d", i));
        end

        // ---- backpressure, with a new operand offered while in DONE ----
        out_ready = 1'b0;
        accept_op(32'sd100000, "bp");
        wait_result(32'sd60724, "bp");
        held      = mag_out;
        in_valid  = 1'b1;
        x_in      = -32'sd100000;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mag_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_clear", out_valid, 0);
        chk("bp_back_idle", in_ready, 1);
        // in_valid is still high: the operand is taken on this edge, not the earlier one.
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_late_accept", in_ready, 0);
        wait_result(-32'sd60724, "bp_next");
        @(posedge clk); #1;
        chk("bp_next_clear", out_valid, 0);

        // ---- reset during CALC ----
        accept_op(32'sd100000, "abort");
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_mag_out", mag_out, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) stable = 1'b0;
        end
        chk("abort_no_stale_valid", stable, 0 + 1);
        do_op(32'sd32768, 32'sd19898, "after_abort");

        // ---- reset during DONE ----
        out_ready = 1'b0;
        accept_op(32'sd2147483647, "abort_done");
        wait_result(32'sd1304035327, "abort_done");
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_done_valid", out_valid, 0);
        chk("abort_done_mag", mag_out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        do_op(-32'sd100000, -32'sd60724, "after_abort_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
